// File: rtl/cpu_pkg.sv
// Shared constants and small types for the MIPS core.
// Register address/count types used by the register file and scoreboard.
package cpu_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  localparam logic [1:0] PENDING_MAX = 2'd3;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [1:0] pend_t;

endpackage

// File: rtl/cpu_regfile_scoreboard.sv
// Pending-write scoreboard: per-register 2-bit claim counters,
// claim stall, operand-ready terms and a sticky underflow error flag.
// Ports: clock/reset, write_reg, read_reg_a/b, claim_valid/claim_reg in;
// read_ready_a/b, claim_stall, scoreboard_error out.
module cpu_regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_COUNT = 32
) (
  input  logic      clock,
  input  logic      reset,
  input  reg_addr_t write_reg,
  input  reg_addr_t read_reg_a,
  input  reg_addr_t read_reg_b,
  input  logic      claim_valid,
  input  reg_addr_t claim_reg,
  output logic      read_ready_a,
  output logic      read_ready_b,
  output logic      claim_stall,
  output logic      scoreboard_error
);

  pend_t cnt   [1:REG_COUNT-1];
  pend_t cnt_n [1:REG_COUNT-1];
  logic  err_n;
  logic  claim_ok;
  logic  write_en;

  function automatic pend_t pending(reg_addr_t a);
    pending = '0;
    for (int i = 1; i < REG_COUNT; i++)
      if (a == reg_addr_t'(i)) pending = cnt[i];
  endfunction

  // The write committing now retires the last outstanding claim.
  function automatic logic ready(reg_addr_t a);
    pend_t p;
    p = pending(a);
    ready = (a == REG_ZERO) || (p == 2'd0) ||
            (p == 2'd1 && write_reg == a);
  endfunction

  assign write_en = write_reg != REG_ZERO;

  assign claim_stall = claim_valid &&
                       claim_reg != REG_ZERO &&
                       pending(claim_reg) == PENDING_MAX &&
                       write_reg != claim_reg;

  assign claim_ok = claim_valid && !claim_stall &&
                    claim_reg != REG_ZERO;

  assign read_ready_a = ready(read_reg_a);
  assign read_ready_b = ready(read_reg_b);

  always_comb begin
    err_n = scoreboard_error;
    for (int i = 1; i < REG_COUNT; i++) begin
      cnt_n[i] = cnt[i];
      if (claim_ok && claim_reg == reg_addr_t'(i) &&
          !(write_en && write_reg == reg_addr_t'(i))) begin
        cnt_n[i] = cnt[i] + 2'd1;
      end else if (write_en && write_reg == reg_addr_t'(i) &&
                   !(claim_ok && claim_reg == reg_addr_t'(i))) begin
        // Unclaimed writeback: hold at zero and flag it.
        if (cnt[i] == 2'd0) err_n = 1'b1;
        else cnt_n[i] = cnt[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < REG_COUNT; i++) cnt[i] <= '0;
      scoreboard_error <= 1'b0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) cnt[i] <= cnt_n[i];
      scoreboard_error <= err_n;
    end
  end

endmodule

// File: rtl/cpu_regfile.sv
// General-purpose register file with writeback bypass and claim scoreboard.
// Ports: clock/reset, write_data/write_reg, read_reg_a/b -> read_data_a/b,
// read_ready_a/b, claim_valid/claim_reg -> claim_stall, scoreboard_error.
module cpu_regfile #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  cpu_pkg::reg_addr_t    write_reg,
  input  cpu_pkg::reg_addr_t    read_reg_a,
  input  cpu_pkg::reg_addr_t    read_reg_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  read_ready_a,
  output logic                  read_ready_b,
  input  logic                  claim_valid,
  input  cpu_pkg::reg_addr_t    claim_reg,
  output logic                  claim_stall,
  output logic                  scoreboard_error
);

  // Register 0 has no storage.
  logic [DATA_WIDTH-1:0] mem [1:REG_COUNT-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (write_reg != cpu_pkg::REG_ZERO) begin
      mem[write_reg] <= write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] fetch(
    cpu_pkg::reg_addr_t a
  );
    fetch = '0;
    for (int i = 1; i < REG_COUNT; i++)
      if (a == cpu_pkg::reg_addr_t'(i)) fetch = mem[i];
    if (a != cpu_pkg::REG_ZERO && a == write_reg)
      fetch = write_data;
  endfunction

  always_comb read_data_a = fetch(read_reg_a);
  always_comb read_data_b = fetch(read_reg_b);

  cpu_regfile_scoreboard #(
    .REG_COUNT(REG_COUNT)
  ) u_scoreboard (
    .clock           (clock),
    .reset           (reset),
    .write_reg       (write_reg),
    .read_reg_a      (read_reg_a),
    .read_reg_b      (read_reg_b),
    .claim_valid     (claim_valid),
    .claim_reg       (claim_reg),
    .read_ready_a    (read_ready_a),
    .read_ready_b    (read_ready_b),
    .claim_stall     (claim_stall),
    .scoreboard_error(scoreboard_error)
  );

endmodule

// File: tb/tb_cpu_regfile.sv
// Self-checking bench for cpu_regfile: directed vector table,
// asynchronous reset sequence and a model-checked random phase.
module tb_cpu_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] write_data = '0;
  logic [4:0]  write_reg = '0;
  logic [4:0]  read_reg_a = '0;
  logic [4:0]  read_reg_b = '0;
  logic        claim_valid = 1'b0;
  logic [4:0]  claim_reg = '0;
  logic [31:0] read_data_a, read_data_b;
  logic        read_ready_a, read_ready_b;
  logic        claim_stall, scoreboard_error;

  always #5 clock = ~clock;

  cpu_regfile dut (
    .clock           (clock),
    .reset           (reset),
    .write_data      (write_data),
    .write_reg       (write_reg),
    .read_reg_a      (read_reg_a),
    .read_reg_b      (read_reg_b),
    .read_data_a     (read_data_a),
    .read_data_b     (read_data_b),
    .read_ready_a    (read_ready_a),
    .read_ready_b    (read_ready_b),
    .claim_valid     (claim_valid),
    .claim_reg       (claim_reg),
    .claim_stall     (claim_stall),
    .scoreboard_error(scoreboard_error)
  );

  typedef struct {
    bit          cv;
    logic [4:0]  cr;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] da;
    logic [31:0] db;
    bit          rda;
    bit          rdb;
    bit          stall;
    bit          err;
  } vec_t;

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    bit          rda;
    bit          rdb;
    bit          stall;
    bit          err;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  logic [1:0]  m_cnt [32];
  bit          m_err;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic compare(string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      e = q.pop_front();
      chk({tag, " data_a"}, read_data_a, e.da);
      chk({tag, " data_b"}, read_data_b, e.db);
      chk({tag, " ready_a"}, {31'b0, read_ready_a}, {31'b0, e.rda});
      chk({tag, " ready_b"}, {31'b0, read_ready_b}, {31'b0, e.rdb});
      chk({tag, " stall"}, {31'b0, claim_stall}, {31'b0, e.stall});
      chk({tag, " error"}, {31'b0, scoreboard_error}, {31'b0, e.err});
    end
  endtask

  task automatic drive(bit cv, logic [4:0] cr, logic [4:0] wr,
                       logic [31:0] wd, logic [4:0] ra, logic [4:0] rb);
    @(negedge clock);
    claim_valid = cv;
    claim_reg   = cr;
    write_reg   = wr;
    write_data  = wd;
    read_reg_a  = ra;
    read_reg_b  = rb;
  endtask

  function automatic vec_t mk(bit cv, logic [4:0] cr, logic [4:0] wr,
                              logic [31:0] wd, logic [4:0] ra,
                              logic [4:0] rb, logic [31:0] da,
                              logic [31:0] db, bit rda, bit rdb,
                              bit stall, bit err);
    vec_t v;
    v.cv = cv; v.cr = cr; v.wr = wr; v.wd = wd;
    v.ra = ra; v.rb = rb; v.da = da; v.db = db;
    v.rda = rda; v.rdb = rdb; v.stall = stall; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] m_data(logic [4:0] a, logic [4:0] wr,
                                         logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (a == wr) return wd;
    return m_mem[a];
  endfunction

  function automatic bit m_ready(logic [4:0] a, logic [4:0] wr);
    return a == 5'd0 || m_cnt[a] == 2'd0 ||
           (m_cnt[a] == 2'd1 && wr == a);
  endfunction

  initial begin
    exp_t e;
    bit cv, acc;
    logic [4:0] cr, wr, ra, rb;
    logic [31:0] wd;

    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 31, 31, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 8, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8, 8, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8, 32'hDEADBEEF, 8, 8,
                     32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8, 8,
                     32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h12345678, 0, 8,
                     0, 32'hDEADBEEF, 1, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 3, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 3, 3, 32'hA5A5, 3, 3,
                     32'hA5A5, 32'hA5A5, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 3, 3,
                     32'hA5A5, 32'hA5A5, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 3, 1, 3, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3, 2, 3, 0, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3, 3, 3, 0, 3, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 9, 3, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 9, 32'h99, 9, 0, 32'h99, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 9, 32'h99, 32'h99, 1, 1, 0, 1));
    tbl.push_back(mk(1, 12, 0, 0, 12, 9, 0, 32'h99, 1, 1, 0, 1));
    tbl.push_back(mk(1, 12, 12, 32'hC0FFEE, 12, 12,
                     32'hC0FFEE, 32'hC0FFEE, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 12, 12,
                     32'hC0FFEE, 32'hC0FFEE, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 12, 32'h12, 12, 0, 32'h12, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 12, 0, 32'h12, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12, 0, 32'h12, 1, 1, 0, 1));

    repeat (2) @(negedge clock);
    #2;
    chk("in_reset stall", {31'b0, claim_stall}, 32'd0);
    chk("in_reset error", {31'b0, scoreboard_error}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].cr, tbl[i].wr, tbl[i].wd,
            tbl[i].ra, tbl[i].rb);
      e.da = tbl[i].da; e.db = tbl[i].db;
      e.rda = tbl[i].rda; e.rdb = tbl[i].rdb;
      e.stall = tbl[i].stall; e.err = tbl[i].err;
      q.push_back(e);
      #2;
      compare($sformatf("row%0d", i));
    end

    // Asynchronous reset between edges clears the sticky error.
    drive(0, 0, 0, 0, 9, 12);
    #1 reset = 1'b0;
    #1;
    chk("async_rst error", {31'b0, scoreboard_error}, 32'd0);
    chk("async_rst data_a", read_data_a, 32'd0);
    chk("async_rst data_b", read_data_b, 32'd0);
    chk("async_rst ready_a", {31'b0, read_ready_a}, 32'd1);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_cnt[i] = '0;
    end
    m_err = 1'b0;

    for (int n = 0; n < 400; n++) begin
      cv = 1'($urandom_range(0, 1));
      cr = 5'($urandom_range(0, 7));
      wr = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      wd = $urandom;
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      drive(cv, cr, wr, wd, ra, rb);
      e.da = m_data(ra, wr, wd);
      e.db = m_data(rb, wr, wd);
      e.rda = m_ready(ra, wr);
      e.rdb = m_ready(rb, wr);
      e.stall = cv && cr != 0 && m_cnt[cr] == 2'd3 && wr != cr;
      e.err = m_err;
      q.push_back(e);
      #2;
      compare("rand");
      acc = cv && !e.stall && cr != 0;
      if (wr != 0) m_mem[wr] = wd;
      if (!(acc && wr == cr)) begin
        if (acc) m_cnt[cr] = m_cnt[cr] + 2'd1;
        if (wr != 0) begin
          if (m_cnt[wr] == 2'd0) m_err = 1'b1;
          else m_cnt[wr] = m_cnt[wr] - 2'd1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_regfile.md
# cpu_regfile

General-purpose register file for the five-stage MIPS core, sitting at the far end of the writeback path: it consumes the registered `write_data`/`write_reg` pair from the writeback stage and serves two read ports to decode. A per-register pending-write scoreboard lets decode claim a destination at issue and learn whether a source operand is ready. Write-to-read bypass gives decode the writeback value in the same cycle it is committed.

## Interface
- `DATA_WIDTH`, 32, register width.
- `REG_COUNT`, 32, number of architectural registers; address width is log2(REG_COUNT) = 5.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `write_data`  in  DATA_WIDTH  value from writeback.
- `write_reg`  in  5  destination from writeback; 0 means no write.
- `read_reg_a`, `read_reg_b`  in  5  decode source addresses.
- `read_data_a`, `read_data_b`  out  DATA_WIDTH  operand values, combinational.
- `read_ready_a`, `read_ready_b`  out  1  operand valid this cycle (no outstanding write except the one committing now).
- `claim_valid`  in  1  decode issues an instruction writing `claim_reg`.
- `claim_reg`  in  5  destination being claimed.
- `claim_stall`  out  1  combinational; claim cannot be accepted this cycle.
- `scoreboard_error`  out  1  sticky; writeback to a register with no pending claim.

## Operation
- Storage: REG_COUNT x DATA_WIDTH array. Register 0 is not stored; reads of 0 return 0, writes to 0 discarded.
- Write: on the rising edge with `write_reg != 0`, `array[write_reg] <= write_data`.
- Read: `read_data_x` = 0 if address 0; else `write_data` if `read_reg_x == write_reg` and `write_reg != 0` (bypass); else `array[read_reg_x]`.
- Scoreboard: 2-bit pending count per register 1..31; register 0 has none and is always ready.
- Claim accepted when `claim_valid && !claim_stall && claim_reg != 0`: count[claim_reg] += 1. Claims of register 0 are accepted and ignored.
- `claim_stall` = `claim_valid && claim_reg != 0 && count[claim_reg] == 3 && !(write_reg == claim_reg)`. A write to the same register this cycle frees a slot, so no stall.
- Writeback with `write_reg != 0`: count[write_reg] -= 1.
- Accepted claim and write to the same register in one cycle: count unchanged.
- Writeback to a register whose count is 0 and not claimed this cycle: count stays 0, `scoreboard_error` sets and holds until reset. The data write still happens.
- `read_ready_x` = 1 if address 0, or count == 0, or (count == 1 and `write_reg == read_reg_x`). A claim in the same cycle does not affect readiness that cycle.
- Both read ports may address the same register; results are identical.

## Timing
- Reset (`reset` low, asynchronous): all array entries 0, all counts 0, `scoreboard_error` 0. Combinational outputs then read 0 data, ready 1, `claim_stall` 0.
- A write is visible through the bypass in its commit cycle and from the array in the following cycle.
- Claim-to-not-ready latency: one cycle (count updates at the edge).
- Reset asserted mid-operation discards all pending counts; in-flight writebacks arriving after reset release count as errors. Pipeline flush is the core's responsibility.
- No multicycle paths; the read path is array mux plus bypass compare, within one cycle.

## Structure
- Shared package `cpu_pkg`: `REG_ADDR_WIDTH` = 5, `DATA_WIDTH` = 32, `REG_ZERO` = 5'd0, `PENDING_MAX` = 2'd3.
- One natural sub-module: `cpu_regfile_scoreboard` (pending counters, claim_stall, ready terms, error flag). The data array and bypass stay in the top.

## Test plan
- Reset, then read registers 0, 5 and 31 on both ports -> data 0, ready 1, `scoreboard_error` 0.
- Claim reg 8; next cycle read 8 -> ready 0. Writeback `write_reg`=8, `write_data`=0xDEADBEEF -> same cycle `read_data_a`=0xDEADBEEF, ready 1. Following cycle -> array returns 0xDEADBEEF, count 0.
- Writeback reg 0 with 0x12345678 -> read 0 returns 0, no error, no count change.
- Claim reg 3 three times -> fourth claim sees `claim_stall`=1. Repeat the fourth claim alongside writeback to 3 -> stall 0, count stays 3.
- Writeback to reg 9 with no claim -> `scoreboard_error`=1 stays high, reg 9 holds the written value. Pull `reset` low between edges -> error clears at once, no clock needed.
- Simultaneous claim and writeback to reg 12 with count 1 -> count stays 1, `read_ready` for 12 is 1 in that cycle (bypass) and 0 the next cycle.
